// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: pipelined signed W x W multiplier with a per-transaction
// exact/approximate mode. Approximate mode drops every partial-product bit
// a[i]&b[j] whose column i+j lies below APPROX_COLS. The product is formed
// combinationally ahead of the first register. LATENCY stages then carry it
// under one shared advance enable, and every stage holds when the output stalls.

module approx_mult_pipe #(
    parameter int W           = 8,
    parameter int APPROX_COLS = 4,
    parameter int LATENCY     = 2,
    parameter int TAG_W       = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       a,
    input  logic [W-1:0]       b,
    input  logic               approx,
    input  logic [TAG_W-1:0]   tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*W-1:0]     y,
    output logic [TAG_W-1:0]   y_tag,
    output logic [15:0]        approx_count
);

    localparam int PW = 2 * W;

    logic               adv;
    logic [PW-1:0]      exact_prod;
    logic [PW-1:0]      trunc_sum;
    logic [PW-1:0]      prod_sel;

    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] apx_q;
    logic [PW-1:0]      prod_q [LATENCY];
    logic [TAG_W-1:0]   tag_q  [LATENCY];
    logic [15:0]        count_q;

    // Sign-extending both operands to 2W bits makes the low 2W bits of the
    // unsigned product equal the signed product, including (-2^(W-1))^2.
    assign exact_prod = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};

    // Sum of the omitted low-column partial products. Every column is below
    // W-1, so only non-sign bits take part and each term is a plain AND.
    always_comb begin
        trunc_sum = '0;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                if (i + j < APPROX_COLS) begin
                    trunc_sum = trunc_sum + (PW'(a[i] & b[j]) << (i + j));
                end
            end
        end
    end

    // Mode select ahead of the first stage
    always_comb begin
        prod_sel = exact_prod;
        if (approx) begin
            prod_sel = exact_prod - trunc_sum;
        end
    end

    // Whole pipeline advances together; a stalled output freezes every stage
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[LATENCY-1];
    assign y         = prod_q[LATENCY-1];
    assign y_tag     = tag_q[LATENCY-1];

    // Pipeline stages: valid bit, product, tag and mode move as one record
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            apx_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                prod_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else if (adv) begin
            vld_q[0]  <= in_valid;
            apx_q[0]  <= approx;
            prod_q[0] <= prod_sel;
            tag_q[0]  <= tag;
            for (int k = 1; k < LATENCY; k++) begin
                vld_q[k]  <= vld_q[k-1];
                apx_q[k]  <= apx_q[k-1];
                prod_q[k] <= prod_q[k-1];
                tag_q[k]  <= tag_q[k-1];
            end
        end
    end

    // Saturating count of approximate results handed to the consumer
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (out_valid && out_ready && apx_q[LATENCY-1] && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign approx_count = count_q;

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Bench for approx_mult_pipe. The main instance (W=8, 4 cols, latency 2) gets
// table vectors, a random backpressured stream, a stall and a mid-flight reset.
// Two W=4 instances (3 cols/lat 1 and 0 cols/lat 4) get an exhaustive sweep.
// A W=16 instance (15 cols/lat 4) gets random operands. Scoreboards
// check every delivered result against the truncation formula.

module tb_approx_mult_pipe;

    localparam int W    = 8;
    localparam int COLS = 4;
    localparam int LAT  = 2;

    typedef struct {
        longint     y;
        logic [3:0] tag;
        bit         ap;
    } sb_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        bit         ap;
        logic [3:0] tag;
        longint     y;
    } tv_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main instance
    logic        in_valid, in_ready, approx, out_valid, out_ready;
    logic [7:0]  a, b;
    logic [3:0]  tag, y_tag;
    logic [15:0] y, approx_count;

    // W=4 pair, shared stimulus
    logic        s4_valid, s4_ap;
    logic [3:0]  s4_a, s4_b, s4_tag;
    logic        r4a_rdy, r4a_vld, r4b_rdy, r4b_vld;
    logic [7:0]  r4a_y, r4b_y;
    logic [3:0]  r4a_tag, r4b_tag;
    logic [15:0] r4a_cnt, r4b_cnt;

    // W=16 instance
    logic        s16_valid, s16_ap, r16_rdy, r16_vld;
    logic [15:0] s16_a, s16_b;
    logic [3:0]  s16_tag, r16_tag;
    logic [31:0] r16_y;
    logic [15:0] r16_cnt;

    int  n_vec  = 0;
    int  n_fail = 0;
    bit  rand_ready = 1'b0;
    sb_t q8[$], q4a[$], q4b[$], q16[$];
    int  cnt8 = 0, cnt4a = 0, cnt4b = 0, cnt16 = 0;
    sb_t e8, e4a, e4b, e16;

    approx_mult_pipe #(.W(W), .APPROX_COLS(COLS), .LATENCY(LAT), .TAG_W(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .approx(approx), .tag(tag), .out_valid(out_valid), .out_ready(out_ready), .y(y),
        .y_tag(y_tag), .approx_count(approx_count)
    );

    approx_mult_pipe #(.W(4), .APPROX_COLS(3), .LATENCY(1), .TAG_W(4)) u_w4a (
        .clk(clk), .rst(rst), .in_valid(s4_valid), .in_ready(r4a_rdy), .a(s4_a), .b(s4_b),
        .approx(s4_ap), .tag(s4_tag), .out_valid(r4a_vld), .out_ready(1'b1), .y(r4a_y),
        .y_tag(r4a_tag), .approx_count(r4a_cnt)
    );

    approx_mult_pipe #(.W(4), .APPROX_COLS(0), .LATENCY(4), .TAG_W(4)) u_w4b (
        .clk(clk), .rst(rst), .in_valid(s4_valid), .in_ready(r4b_rdy), .a(s4_a), .b(s4_b),
        .approx(s4_ap), .tag(s4_tag), .out_valid(r4b_vld), .out_ready(1'b1), .y(r4b_y),
        .y_tag(r4b_tag), .approx_count(r4b_cnt)
    );

    approx_mult_pipe #(.W(16), .APPROX_COLS(15), .LATENCY(4), .TAG_W(4)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(s16_valid), .in_ready(r16_rdy), .a(s16_a),
        .b(s16_b), .approx(s16_ap), .tag(s16_tag), .out_valid(r16_vld), .out_ready(1'b1),
        .y(r16_y), .y_tag(r16_tag), .approx_count(r16_cnt)
    );

    // Reference: exact product minus the omitted low-column partial products
    function automatic longint ref_y(input longint ra, input longint rb, input bit ap,
                                     input int w, input int cols);
        longint r;
        r = ra * rb;
        if (ap) begin
            for (int i = 0; i < w; i++) begin
                for (int j = 0; j < w; j++) begin
                    if ((i + j < cols) && ra[i] && rb[j]) begin
                        r = r - (longint'(1) << (i + j));
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic void checkv(input string name, input longint act, input longint req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    function automatic void chk1(input string name, input logic act, input logic req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Main scoreboard: pop on output transfer, push on input acceptance
    always @(negedge clk) begin
        if (rst) begin
            q8.delete();
            cnt8 = 0;
        end else begin
            chk1("in_ready", in_ready, !(out_valid && !out_ready));
            checkv("approx_count", longint'(approx_count), longint'(cnt8));
            if (out_valid && out_ready) begin
                if (q8.size() == 0) begin
                    chk1("spurious output", 1'b1, 1'b0);
                end else begin
                    e8 = q8.pop_front();
                    checkv("y", longint'($signed(y)), e8.y);
                    checkv("y_tag", longint'(y_tag), longint'(e8.tag));
                    if (e8.ap && cnt8 < 65535) cnt8++;
                end
            end
            if (in_valid && in_ready) begin
                q8.push_back('{y: ref_y(longint'($signed(a)), longint'($signed(b)), approx,
                                        W, COLS), tag: tag, ap: approx});
            end
        end
    end

    // Secondary scoreboards (consumers always ready)
    always @(negedge clk) begin
        if (rst) begin
            q4a.delete(); q4b.delete(); q16.delete();
            cnt4a = 0; cnt4b = 0; cnt16 = 0;
        end else begin
            checkv("w4a approx_count", longint'(r4a_cnt), longint'(cnt4a));
            checkv("w4b approx_count", longint'(r4b_cnt), longint'(cnt4b));
            checkv("w16 approx_count", longint'(r16_cnt), longint'(cnt16));
            if (r4a_vld) begin
                if (q4a.size() == 0) chk1("w4a spurious", 1'b1, 1'b0);
                else begin
                    e4a = q4a.pop_front();
                    checkv("w4a y", longint'($signed(r4a_y)), e4a.y);
                    checkv("w4a y_tag", longint'(r4a_tag), longint'(e4a.tag));
                    if (e4a.ap) cnt4a++;
                end
            end
            if (r4b_vld) begin
                if (q4b.size() == 0) chk1("w4b spurious", 1'b1, 1'b0);
                else begin
                    e4b = q4b.pop_front();
                    checkv("w4b y", longint'($signed(r4b_y)), e4b.y);
                    checkv("w4b y_tag", longint'(r4b_tag), longint'(e4b.tag));
                    if (e4b.ap) cnt4b++;
                end
            end
            if (r16_vld) begin
                if (q16.size() == 0) chk1("w16 spurious", 1'b1, 1'b0);
                else begin
                    e16 = q16.pop_front();
                    checkv("w16 y", longint'($signed(r16_y)), e16.y);
                    checkv("w16 y_tag", longint'(r16_tag), longint'(e16.tag));
                    if (e16.ap) cnt16++;
                end
            end
            if (s4_valid) begin
                chk1("w4a in_ready", r4a_rdy, 1'b1);
                chk1("w4b in_ready", r4b_rdy, 1'b1);
                if (r4a_rdy) q4a.push_back('{y: ref_y(longint'($signed(s4_a)),
                    longint'($signed(s4_b)), s4_ap, 4, 3), tag: s4_tag, ap: s4_ap});
                if (r4b_rdy) q4b.push_back('{y: ref_y(longint'($signed(s4_a)),
                    longint'($signed(s4_b)), s4_ap, 4, 0), tag: s4_tag, ap: s4_ap});
            end
            if (s16_valid) begin
                chk1("w16 in_ready", r16_rdy, 1'b1);
                if (r16_rdy) q16.push_back('{y: ref_y(longint'($signed(s16_a)),
                    longint'($signed(s16_b)), s16_ap, 16, 15), tag: s16_tag, ap: s16_ap});
            end
        end
    end

    // Random backpressure while enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    // Offer one transaction and hold it until accepted
    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input bit tap,
                        input logic [3:0] ttag);
        bit acc;
        int guard;
        guard = 0;
        a = ta; b = tb; approx = tap; tag = ttag; in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            step();
            guard++;
        end while (!acc && guard < 200);
        if (!acc) chk1("send accepted", 1'b0, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((q8.size() != 0 || out_valid) && guard < 100) begin
            step();
            guard++;
        end
        checkv("drain queue empty", longint'(q8.size()), 64'd0);
    endtask

    tv_t    tv[14];
    int     n_acc;
    bit     acc;
    longint y_hold;
    logic [3:0] t_hold;

    initial begin
        tv[0]  = '{8'h07, 8'h07, 1'b0, 4'h0, 49};
        tv[1]  = '{8'h07, 8'h07, 1'b1, 4'h1, 16};
        tv[2]  = '{8'hFF, 8'hFF, 1'b0, 4'h2, 1};
        tv[3]  = '{8'hFF, 8'hFF, 1'b1, 4'h3, -48};
        tv[4]  = '{8'h80, 8'h80, 1'b0, 4'h4, 16384};
        tv[5]  = '{8'h80, 8'h80, 1'b1, 4'h5, 16384};
        tv[6]  = '{8'h05, 8'hFD, 1'b0, 4'h6, -15};
        tv[7]  = '{8'h05, 8'hFD, 1'b1, 4'h7, -32};
        tv[8]  = '{8'h7F, 8'h7F, 1'b0, 4'h8, 16129};
        tv[9]  = '{8'h7F, 8'h7F, 1'b1, 4'h9, 16080};
        tv[10] = '{8'h80, 8'h7F, 1'b1, 4'hA, -16256};
        tv[11] = '{8'h03, 8'h03, 1'b1, 4'hB, 0};
        tv[12] = '{8'h10, 8'h01, 1'b1, 4'hC, 16};
        tv[13] = '{8'h00, 8'hFF, 1'b1, 4'hD, 0};

        in_valid = 1'b0; a = '0; b = '0; approx = 1'b0; tag = '0; out_ready = 1'b1;
        s4_valid = 1'b0; s4_a = '0; s4_b = '0; s4_ap = 1'b0; s4_tag = '0;
        s16_valid = 1'b0; s16_a = '0; s16_b = '0; s16_ap = 1'b0; s16_tag = '0;

        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk1("reset out_valid", out_valid, 1'b0);
        chk1("reset in_ready", in_ready, 1'b1);
        checkv("reset approx_count", longint'(approx_count), 64'd0);
        step();

        // Table vectors, one at a time, checking exact latency
        for (int i = 0; i < 14; i++) begin
            a = tv[i].a; b = tv[i].b; approx = tv[i].ap; tag = tv[i].tag; in_valid = 1'b1;
            @(negedge clk);
            chk1("table accept", in_ready, 1'b1);
            step();
            in_valid = 1'b0;
            @(negedge clk);
            chk1("table early out_valid", out_valid, 1'b0);
            step();
            @(negedge clk);
            chk1("table out_valid", out_valid, 1'b1);
            checkv("table y", longint'($signed(y)), tv[i].y);
            checkv("table y_tag", longint'(y_tag), longint'(tv[i].tag));
            step();
        end

        // Random stream under random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)));
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        drain();

        // Stall: output held for 6 cycles, only LAT transactions get in
        out_ready = 1'b0;
        n_acc = 0;
        a = 8'd20; b = 8'd3; approx = 1'b0; tag = 4'd8; in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 2) begin
                y_hold = longint'($signed(y));
                t_hold = y_tag;
                chk1("stall out_valid", out_valid, 1'b1);
            end
            if (c > 2) begin
                chk1("stall out_valid held", out_valid, 1'b1);
                checkv("stall y stable", longint'($signed(y)), y_hold);
                checkv("stall y_tag stable", longint'(y_tag), longint'(t_hold));
            end
            acc = in_valid && in_ready;
            step();
            if (acc) begin
                n_acc++;
                a = 8'(20 + n_acc); approx = n_acc[0]; tag = 4'(8 + n_acc);
            end
        end
        checkv("stall accepted count", longint'(n_acc), longint'(LAT));
        out_ready = 1'b1;
        send(a, b, approx, tag);
        drain();

        // Reset with two transactions in flight
        a = 8'h33; b = 8'h0F; approx = 1'b1; tag = 4'h6; in_valid = 1'b1;
        step();
        a = 8'h44; tag = 4'h7;
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk1("pre-reset out_valid", out_valid, 1'b1);
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk1("post-reset out_valid", out_valid, 1'b0);
            checkv("post-reset approx_count", longint'(approx_count), 64'd0);
            step();
        end
        send(8'h09, 8'hFE, 1'b1, 4'hA);
        @(negedge clk);
        chk1("post-reset early", out_valid, 1'b0);
        step();
        @(negedge clk);
        chk1("post-reset deliver", out_valid, 1'b1);
        checkv("post-reset y", longint'($signed(y)), -32);
        checkv("post-reset y_tag", longint'(y_tag), 64'd10);
        step();
        drain();

        // Parameter sweep instances
        fork
            begin
                for (int ai = 0; ai < 16; ai++) begin
                    for (int bi = 0; bi < 16; bi++) begin
                        for (int m = 0; m < 2; m++) begin
                            s4_a = 4'(ai); s4_b = 4'(bi); s4_ap = 1'(m);
                            s4_tag = 4'(ai + bi); s4_valid = 1'b1;
                            step();
                        end
                    end
                end
                s4_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 1000; i++) begin
                    s16_a = 16'($urandom); s16_b = 16'($urandom);
                    s16_ap = 1'($urandom_range(0, 1)); s16_tag = 4'($urandom_range(0, 15));
                    s16_valid = 1'b1;
                    step();
                end
                s16_valid = 1'b0;
            end
        join
        repeat (8) step();
        checkv("w4a queue empty", longint'(q4a.size()), 64'd0);
        checkv("w4b queue empty", longint'(q4b.size()), 64'd0);
        checkv("w16 queue empty", longint'(q16.size()), 64'd0);
        checkv("w4a final approx_count", longint'(r4a_cnt), 64'd256);
        checkv("w4b final approx_count", longint'(r4b_cnt), 64'd256);
        checkv("w16 final approx_count", longint'(r16_cnt), longint'(cnt16));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
